// File: rtl/mem_store_unit.sv
// Byte-serial store engine: takes one SB/SH/SW request per handshake and writes
// it little-endian through the single-byte RAM write port, one byte per clock.
module mem_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  req_size_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_data_i,
  output logic        we_RAM_o,
  output logic [31:0] waddr_RAM_o,
  output logic [7:0]  wdata_RAM_o,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

  state_t      state, state_nx;
  logic [1:0]  cnt, cnt_nx;
  logic [31:0] shift, shift_nx;
  logic [31:0] addr, addr_nx;
  logic [7:0]  wdata, wdata_nx;
  logic        last_byte;
  logic        accept;
  logic        load;

  // Handshake: a request transfers on a rising edge where req_valid_i and
  // req_ready_o are both high; the source holds req_* stable until then.
  // Ready reopens in the last-byte cycle so back-to-back stores have no bubble.
  assign last_byte   = (state == WRITE) && (cnt == 2'd0);
  assign req_ready_o = (state == IDLE) || last_byte;
  assign accept      = req_valid_i && req_ready_o;
  assign load        = accept && (req_size_i != 2'b11);

  assign we_RAM_o    = (state == WRITE);
  assign busy_o      = (state == WRITE);
  assign done_o      = last_byte;
  assign waddr_RAM_o = addr;
  assign wdata_RAM_o = wdata;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    shift_nx = shift;
    addr_nx  = addr;
    wdata_nx = wdata;
    if (load) begin
      state_nx = WRITE;
      addr_nx  = req_addr_i;
      wdata_nx = req_data_i[7:0];
      shift_nx = req_data_i >> 8;
      cnt_nx   = (req_size_i == 2'b00) ? 2'd0 :
                 (req_size_i == 2'b01) ? 2'd1 : 2'd3;
    end else if (state == WRITE) begin
      if (cnt != 2'd0) begin
        addr_nx  = addr + 32'd1;
        wdata_nx = shift[7:0];
        shift_nx = shift >> 8;
        cnt_nx   = cnt - 2'd1;
      end else begin
        // Reserved-size accepts in the last-byte cycle also land here.
        state_nx = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 2'd0;
      shift <= 32'd0;
      addr  <= 32'd0;
      wdata <= 8'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      shift <= shift_nx;
      addr  <= addr_nx;
      wdata <= wdata_nx;
    end
  end

endmodule
